inst_cache_assoc: RTL and testbench

//  Parametrised set-associative, read-only instruction cache for the pipelined RV32I core.

---
 rtl/inst_cache_assoc.sv | 136 +++++++++++++
 tb/tb_inst_cache_assoc.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/inst_cache_assoc.sv
// inst_cache_assoc: set-associative read-only instruction cache with LRU refill and perf counters
module inst_cache_assoc #(
  parameter int LINE_ADDR_LEN = 2,
  parameter int SET_ADDR_LEN  = 3,
  parameter int WAY_CNT       = 2,
  localparam int TAG_ADDR_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [29:0] addr,
  output logic [31:0] rd_data,
  output logic        miss,
  input  logic        flush,
  output logic        mem_rd_req,
  output logic [29:0] mem_rd_addr,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int LINE_W = 1 << LINE_ADDR_LEN;
  localparam int SET_N = 1 << SET_ADDR_LEN;
  localparam int WAY_W = WAY_CNT > 1 ? $clog2(WAY_CNT) : 1;
  localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAY_CNT - 1);
  typedef enum logic {IDLE, REFILL} state_t;
  state_t state_q;
  logic [31:0] data_q [SET_N][WAY_CNT][LINE_W];
  logic [TAG_ADDR_LEN-1:0] tag_q [SET_N][WAY_CNT];
  logic valid_q [SET_N][WAY_CNT];
  logic [WAY_W-1:0] age_q [SET_N][WAY_CNT];
  logic [WAY_W-1:0] victim_q, victim_d, hit_way, best_age;
  logic [LINE_ADDR_LEN-1:0] beat_q;
  logic flush_pend_q, mem_rd_req_q, hit, hit_d, has_inv;
  logic [29:0] mem_rd_addr_q;
  logic [31:0] rd_data_q, hit_cnt_q, miss_cnt_q;
  logic [TAG_ADDR_LEN-1:0] tag, r_tag;
  logic [SET_ADDR_LEN-1:0] set_idx, r_set;
  logic [LINE_ADDR_LEN-1:0] off;
  assign {tag, set_idx, off} = addr;
  assign r_tag = mem_rd_addr_q[29 -: TAG_ADDR_LEN];
  assign r_set = mem_rd_addr_q[LINE_ADDR_LEN +: SET_ADDR_LEN];
  // Tag lookup plus victim choice: lowest invalid way, otherwise the oldest way
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    victim_d = '0;
    best_age = age_q[set_idx][0];
    for (int w = WAY_CNT - 1; w >= 0; w--) begin
      if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag) begin
        hit = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[set_idx][w]) begin
        has_inv = 1'b1;
        victim_d = WAY_W'(w);
      end
    end
    if (!has_inv)
      for (int w = 1; w < WAY_CNT; w++)
        if (age_q[set_idx][w] > best_age) begin
          best_age = age_q[set_idx][w];
          victim_d = WAY_W'(w);
        end
    if (flush) victim_d = '0;
    hit_d = hit & ~flush;
  end
  assign miss = (state_q != IDLE) | (rd_req & ~hit_d);
  // Fetch/refill state machine, valid and LRU bookkeeping, counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rd_data_q <= '0;
      mem_rd_req_q <= 1'b0;
      mem_rd_addr_q <= '0;
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
      flush_pend_q <= 1'b0;
      victim_q <= '0;
      beat_q <= '0;
      valid_q <= '{default: '0};
      age_q <= '{default: '0};
    end else if (state_q == IDLE) begin
      if (flush) begin
        valid_q <= '{default: '0};
        age_q <= '{default: '0};
      end
      if (rd_req && hit_d) begin
        rd_data_q <= data_q[set_idx][hit_way][off];
        hit_cnt_q <= hit_cnt_q + 32'(hit_cnt_q != '1);
        for (int w = 0; w < WAY_CNT; w++)
          if (WAY_W'(w) == hit_way) age_q[set_idx][w] <= '0;
          else if (age_q[set_idx][w] < age_q[set_idx][hit_way]) age_q[set_idx][w] <= age_q[set_idx][w] + 1'b1;
      end else if (rd_req) begin
        state_q <= REFILL;
        victim_q <= victim_d;
        beat_q <= '0;
        mem_rd_req_q <= 1'b1;
        mem_rd_addr_q <= {tag, set_idx, {LINE_ADDR_LEN{1'b0}}};
        miss_cnt_q <= miss_cnt_q + 32'(miss_cnt_q != '1);
      end
    end else begin
      if (flush) flush_pend_q <= 1'b1;
      if (mem_rd_valid) begin
        beat_q <= beat_q + 1'b1;
        if (beat_q == '1) begin
          state_q <= IDLE;
          mem_rd_req_q <= 1'b0;
          flush_pend_q <= 1'b0;
          if (flush || flush_pend_q) begin
            valid_q <= '{default: '0};
            age_q <= '{default: '0};
          end else begin
            valid_q[r_set][victim_q] <= 1'b1;
            for (int w = 0; w < WAY_CNT; w++)
              age_q[r_set][w] <= (WAY_W'(w) == victim_q) ? '0 :
                                 (age_q[r_set][w] == AGE_MAX) ? AGE_MAX : age_q[r_set][w] + 1'b1;
          end
        end
      end
    end
  end
  // Line data and tags are written only by refill beats and carry no reset
  always_ff @(posedge clk) begin
    if (state_q == REFILL && mem_rd_valid) begin
      data_q[r_set][victim_q][beat_q] <= mem_rd_data;
      if (beat_q == '1) tag_q[r_set][victim_q] <= r_tag;
    end
  end
  assign rd_data = rd_data_q;
  assign mem_rd_req = mem_rd_req_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign hit_cnt = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_inst_cache_assoc.sv
// tb_inst_cache_assoc: directed scoreboard bench for the set-associative instruction cache
module tb_inst_cache_assoc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_req = 1'b0;
  logic [29:0] addr = '0;
  logic [31:0] rd_data;
  logic miss;
  logic flush = 1'b0;
  logic mem_rd_req;
  logic [29:0] mem_rd_addr;
  logic mem_rd_valid = 1'b0;
  logic [31:0] mem_rd_data = '0;
  logic [31:0] hit_cnt, miss_cnt;
  int checks = 0;
  int failures = 0;
  int exp_hits = 0;
  int exp_miss = 0;
  logic [31:0] sb [$];
  inst_cache_assoc dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .addr(addr), .rd_data(rd_data), .miss(miss),
    .flush(flush), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mdata(input logic [29:0] a);
    return (a[29:2] == 28'h4) ? 32'hA0 + 32'(a[1:0]) : {2'b11, a};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_cnt();
    chk("hit_cnt", hit_cnt, 32'(exp_hits));
    chk("miss_cnt", miss_cnt, 32'(exp_miss));
  endtask
  task automatic fetch_hit(input logic [29:0] a);
    @(negedge clk);
    rd_req = 1'b1; addr = a; flush = 1'b0; mem_rd_valid = 1'b0;
    #1 chk("hit_no_stall", miss, 0);
    sb.push_back(mdata(a));
    exp_hits++;
    @(posedge clk);
    #1 chk("hit_rd_data", rd_data, sb.pop_front());
  endtask
  task automatic fetch_miss(input logic [29:0] a, input int gap, input bit fl_first, input int fl_beat);
    logic [29:0] base;
    base = {a[29:2], 2'b00};
    @(negedge clk);
    rd_req = 1'b1; addr = a; flush = fl_first; mem_rd_valid = 1'b0;
    #1 chk("miss_start", miss, 1);
    exp_miss++;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("mem_rd_req_set", mem_rd_req, 1);
    chk("mem_rd_addr", mem_rd_addr, base);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        mem_rd_valid = 1'b0; flush = 1'b0;
        #1 chk("miss_in_gap", miss, 1);
      end
      @(negedge clk);
      mem_rd_valid = 1'b1; mem_rd_data = mdata(base + 30'(i)); flush = (i == fl_beat);
      #1 chk("miss_in_beat", miss, 1);
    end
    @(negedge clk);
    mem_rd_valid = 1'b0; flush = 1'b0;
    #1 chk("mem_rd_req_clr", mem_rd_req, 0);
    if (fl_beat >= 0) begin
      chk("relookup_after_flush", miss, 1);
      rd_req = 1'b0;
    end else begin
      chk("relookup_hit", miss, 0);
      sb.push_back(mdata(a));
      exp_hits++;
      @(posedge clk);
      #1 chk("refill_rd_data", rd_data, sb.pop_front());
    end
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_mem_rd_req", mem_rd_req, 0);
    chk("rst_mem_rd_addr", mem_rd_addr, 0);
    chk("rst_miss", miss, 0);
    chk_cnt();
    rst = 1'b0;
    fetch_miss(30'h10, 0, 1'b0, -1);
    fetch_hit(30'h13);
    chk("c1_rd_data", rd_data, 32'hA3);
    chk_cnt();
    fetch_miss(30'h54, 3, 1'b0, -1);
    fetch_hit(30'h55);
    fetch_hit(30'h57);
    fetch_hit(30'h56);
    fetch_miss(30'h000, 0, 1'b0, -1);
    fetch_miss(30'h020, 0, 1'b0, -1);
    fetch_hit(30'h000);
    fetch_miss(30'h040, 0, 1'b0, -1);
    fetch_hit(30'h000);
    fetch_miss(30'h020, 0, 1'b0, -1);
    chk_cnt();
    fetch_miss(30'h4, 0, 1'b0, -1);
    fetch_miss(30'h8, 0, 1'b0, -1);
    fetch_miss(30'hC, 0, 1'b0, -1);
    for (int i = 0; i < 16; i++) fetch_hit(30'(i));
    chk_cnt();
    @(negedge clk);
    rd_req = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    fetch_miss(30'h10, 0, 1'b0, -1);
    chk_cnt();
    fetch_miss(30'h10, 0, 1'b1, -1);
    fetch_miss(30'h8, 0, 1'b0, 2);
    fetch_miss(30'h8, 0, 1'b0, -1);
    fetch_miss(30'h10, 1, 1'b0, -1);
    chk_cnt();
    @(negedge clk);
    rd_req = 1'b1; addr = 30'h70; flush = 1'b0;
    @(posedge clk);
    #1 chk("pre_rst_mem_rd_req", mem_rd_req, 1);
    @(negedge clk);
    mem_rd_valid = 1'b1; mem_rd_data = mdata(30'h70);
    @(negedge clk);
    mem_rd_valid = 1'b0; rd_req = 1'b0; rst = 1'b1;
    #1 chk("midrst_mem_rd_req", mem_rd_req, 0);
    chk("midrst_miss", miss, 0);
    chk("midrst_rd_data", rd_data, 0);
    exp_hits = 0;
    exp_miss = 0;
    chk_cnt();
    @(negedge clk);
    rst = 1'b0;
    fetch_miss(30'h10, 0, 1'b0, -1);
    chk_cnt();
    @(negedge clk);
    rd_req = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
